// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared definitions for the LED sequencer: mode encodings,
//               button bit positions, default tick periods, rate-select
//               width and the command priority decoder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    // Mode encoding matches the external o_mode field.
    typedef enum logic [1:0] {
        MODE_SHIFT_L = 2'd0,
        MODE_SHIFT_R = 2'd1,
        MODE_FLASH   = 2'd2,
        MODE_STOP    = 2'd3
    } mode_t;

    // Decoded command: valid when at least one button edge was seen.
    typedef struct packed {
        logic  valid;
        mode_t mode;
    } cmd_t;

    localparam int unsigned NB_BTN      = 4;
    localparam int unsigned BTN_SHIFT_L = 0;
    localparam int unsigned BTN_SHIFT_R = 1;
    localparam int unsigned BTN_FLASH   = 2;
    localparam int unsigned BTN_STOP    = 3;

    // Width of the rate-select field taken from the switch bank.
    localparam int unsigned RATE_W = 2;

    // Default prescaler limits; each tick period is LIMIT+1 cycles.
    localparam int unsigned DEF_LIMIT0 = (1 << 23) - 1;
    localparam int unsigned DEF_LIMIT1 = (1 << 24) - 1;
    localparam int unsigned DEF_LIMIT2 = (1 << 25) - 1;
    localparam int unsigned DEF_LIMIT3 = (1 << 26) - 1;

    // Resolve simultaneous button edges: STOP > FLASH > SHIFT_R > SHIFT_L.
    function automatic cmd_t decode_cmd(input logic [NB_BTN-1:0] rise);
        cmd_t c;
        c.valid = |rise;
        c.mode  = MODE_SHIFT_L;
        if (rise[BTN_STOP]) begin
            c.mode = MODE_STOP;
        end else if (rise[BTN_FLASH]) begin
            c.mode = MODE_FLASH;
        end else if (rise[BTN_SHIFT_R]) begin
            c.mode = MODE_SHIFT_R;
        end else begin
            c.mode = MODE_SHIFT_L;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_seq_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Enable-gated prescaler. Counts up while enabled and emits a
//               one-cycle tick when the count reaches or passes the limit.
// Ports       : clock   - system clock
//               i_reset - synchronous active-high reset
//               enable  - count enable; when low the count holds, no tick
//               limit   - terminal count (period = limit + 1 cycles)
//               tick    - registered one-cycle strobe
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned NB_COUNT = 32
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                enable,
    input  logic [NB_COUNT-1:0] limit,
    output logic                tick
);

    localparam logic [NB_COUNT-1:0] C_ONE = NB_COUNT'(1);

    logic [NB_COUNT-1:0] count;

    // A >= compare lets a lowered limit fire on the very next edge instead
    // of letting the counter wrap all the way around.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (enable) begin
            if (count >= limit) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + C_ONE;
                tick  <= 1'b0;
            end
        end else begin
            tick  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : LED pattern sequencer. Button rising edges select a mode
//               (shift left, shift right, flash, stop); a prescaled tick
//               advances the LED pattern one cycle after each strobe.
// Ports       : clock   - system clock
//               i_reset - synchronous active-high reset
//               i_sw    - [0] run enable, [2:1] rate select (LIMIT0..3)
//               i_btn   - level buttons: [0] SHIFT_L [1] SHIFT_R
//                         [2] FLASH [3] STOP
//               o_led   - registered LED pattern
//               o_tick  - one-cycle strobe at each pattern-update instant
//               o_mode  - current mode (0 SHIFT_L, 1 SHIFT_R, 2 FLASH, 3 STOP)
// Notes       : NB_LEDS must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned NB_LEDS  = 4,
    parameter int unsigned NB_COUNT = 32,
    parameter int unsigned LIMIT0   = DEF_LIMIT0,
    parameter int unsigned LIMIT1   = DEF_LIMIT1,
    parameter int unsigned LIMIT2   = DEF_LIMIT2,
    parameter int unsigned LIMIT3   = DEF_LIMIT3
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [2:0]         i_sw,
    input  logic [NB_BTN-1:0]  i_btn,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_tick,
    output logic [1:0]         o_mode
);

    localparam logic [NB_LEDS-1:0] C_LED_ONE_HOT = NB_LEDS'(1);

    logic [NB_BTN-1:0]   btn_q;
    logic [NB_BTN-1:0]   btn_mask;
    logic [NB_BTN-1:0]   rise;
    cmd_t                cmd;
    logic                run_en;
    logic [RATE_W-1:0]   rate_sel;
    logic [NB_COUNT-1:0] limit_sel;

    mode_t               mode_q;
    mode_t               mode_d;
    logic [NB_LEDS-1:0]  led_q;
    logic [NB_LEDS-1:0]  led_d;

    assign run_en   = i_sw[0];
    assign rate_sel = i_sw[2:1];

    // ------------------------------------------------------------------
    // Rate selection; a change takes effect in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        limit_sel = NB_COUNT'(LIMIT0);
        unique case (rate_sel)
            2'd0:    limit_sel = NB_COUNT'(LIMIT0);
            2'd1:    limit_sel = NB_COUNT'(LIMIT1);
            2'd2:    limit_sel = NB_COUNT'(LIMIT2);
            default: limit_sel = NB_COUNT'(LIMIT3);
        endcase
    end

    tick_gen #(
        .NB_COUNT (NB_COUNT)
    ) u_tick_gen (
        .clock   (clock),
        .i_reset (i_reset),
        .enable  (run_en),
        .limit   (limit_sel),
        .tick    (o_tick)
    );

    // ------------------------------------------------------------------
    // Button edge detection. The button registers are cleared by reset,
    // so a button held through reset release would otherwise look like a
    // fresh press. btn_mask is set by reset and each bit drops only once
    // that button has been seen released, suppressing the false edge.
    // ------------------------------------------------------------------
    assign rise = i_btn & ~btn_q & ~btn_mask;
    assign cmd  = decode_cmd(rise);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (i_reset) begin
            btn_q    <= '0;
            btn_mask <= '1;
            mode_q   <= MODE_SHIFT_L;
            led_q    <= C_LED_ONE_HOT;
        end else begin
            btn_q    <= i_btn;
            btn_mask <= btn_mask & i_btn;
            mode_q   <= mode_d;
            led_q    <= led_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A real mode change has priority over a pending
    // pattern update, which is dropped for that edge. A command naming
    // the current mode is not a transition and lets the update proceed.
    // ------------------------------------------------------------------
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        if (cmd.valid && (cmd.mode != mode_q)) begin
            mode_d = cmd.mode;
            // Leaving flash/stop for a shift mode restarts from bit 0;
            // shift-to-shift and entering flash/stop keep the pattern.
            if (((mode_q == MODE_FLASH) || (mode_q == MODE_STOP)) &&
                ((cmd.mode == MODE_SHIFT_L) || (cmd.mode == MODE_SHIFT_R))) begin
                led_d = C_LED_ONE_HOT;
            end
        end else if (o_tick) begin
            unique case (mode_q)
                MODE_SHIFT_L: led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
                MODE_SHIFT_R: led_d = {led_q[0], led_q[NB_LEDS-1:1]};
                MODE_FLASH:   led_d = ~led_q;
                MODE_STOP:    led_d = led_q;
                default:      led_d = led_q;
            endcase
        end
    end

    assign o_led  = led_q;
    assign o_mode = mode_q;

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter NB_LEDS, default 4, SHALL set the LED vector width (minimum 2).
REQ-002 Parameter NB_COUNT, default 32, SHALL set the prescaler counter width.
REQ-003 Parameters LIMIT0..LIMIT3, defaults 2**23-1, 2**24-1, 2**25-1, 2**26-1, SHALL set the four tick periods; each period is LIMITn+1 cycles.
REQ-004 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_sw  input  3  i_sw[0] = run enable; i_sw[2:1] = rate select (0..3 selects LIMIT0..LIMIT3).
REQ-007 i_btn  input  4  level commands: [0] SHIFT_L, [1] SHIFT_R, [2] FLASH, [3] STOP.
REQ-008 o_led  output  NB_LEDS  registered LED pattern.
REQ-009 o_tick  output  1  one-cycle strobe marking each pattern-update instant; it can also drive an external flash block's valid.
REQ-010 o_mode  output  2  current mode: 0 SHIFT_L, 1 SHIFT_R, 2 FLASH, 3 STOP.

Function
REQ-011 Each i_btn bit SHALL be registered once; a command SHALL be the rising edge (registered value low, current value high), so a held button issues exactly one command.
REQ-012 When several command edges occur in the same cycle, priority SHALL be STOP > FLASH > SHIFT_R > SHIFT_L.
REQ-013 A command SHALL set o_mode on the next edge; a command equal to the current mode SHALL be ignored.
REQ-014 A transition from FLASH or STOP into SHIFT_L or SHIFT_R SHALL load o_led = one-hot bit 0 on the same edge. SHIFT_L<->SHIFT_R transitions SHALL keep o_led.
REQ-015 A transition into FLASH or STOP SHALL keep o_led.
REQ-016 With i_sw[0]=1, the prescaler SHALL increment by 1 per cycle. When count >= the selected LIMIT, the next edge SHALL clear count to 0 and assert o_tick for exactly that one cycle.
REQ-017 With i_sw[0]=0, the prescaler SHALL hold its count, o_tick SHALL stay 0, and o_led SHALL hold.
REQ-018 A rate change mid-count SHALL take effect immediately. If count already exceeds the new limit, the tick SHALL fire on the next edge (>= compare, no wrap through 2**NB_COUNT).
REQ-019 o_led SHALL update on the edge after the o_tick cycle (latency 1 from tick) as follows:
  - SHIFT_L: rotate left, MSB to bit 0.
  - SHIFT_R: rotate right, bit 0 to MSB.
  - FLASH: bitwise invert.
  - STOP: hold.
REQ-020 The prescaler SHALL run in STOP mode too (o_tick still pulses); only o_led holds.
REQ-021 If a mode command and a pending LED update coincide on the same edge, the mode transition (REQ-014/015) SHALL win and the update SHALL be dropped.

Reset
REQ-022 While i_reset=1, the following SHALL apply on every edge, overriding all other inputs:
  - o_led = {NB_LEDS-1 zeros, 1}
  - o_mode = SHIFT_L
  - o_tick = 0
  - count = 0
  - button registers = 0
REQ-023 A button held through reset release SHALL NOT generate a command until it is released and pressed again.

Structure
REQ-024 Package led_seq_pkg SHALL hold the mode encodings, the default LIMIT values and the rate-select width.
REQ-025 The prescaler SHALL be a sub-module tick_gen (inputs: enable, limit; output: tick); mode FSM, button edge detection and LED register stay in led_seq_ctrl.

Verification (LIMIT0=3, LIMIT1=5, LIMIT2=7, LIMIT3=1, NB_LEDS=4)
REQ-026 Reset, i_sw=001, no buttons -> o_tick every 4 cycles; o_led 0001->0010->0100->1000->0001.
REQ-027 Pulse i_btn[2] while o_led=0100 -> o_mode=2; o_led 0100->1011->0100 on successive ticks.
REQ-028 From FLASH with o_led=1011, pulse i_btn[1] -> o_led=0001 next edge, then 1000, 0100 on ticks.
REQ-029 Assert i_btn=1111 for 10 cycles -> o_mode=3 after one command; o_led frozen; o_tick still pulses every 4 cycles.
REQ-030 Count=6 with rate 2 selected; switch i_sw[2:1] to 3 -> o_tick on the next edge, then every 2 cycles.
REQ-031 i_sw[0]=0 for 20 cycles mid-count -> no ticks, o_led and count frozen; re-enable -> resumes from the held count. Reset asserted mid-run with i_btn[0] held -> REQ-022 values, and no command after release.
